// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX register-use inputs plus stall/flush controls and counters.
interface hazard_ctrl_if;
  logic [4:0]  id_Rn;
  logic [4:0]  id_Rm;
  logic        id_uses_Rm;
  logic [4:0]  ex_Rd;
  logic        ex_MemRead;
  logic        ex_RegWrite;
  logic        ex_BrTaken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        stall_active;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_Rn, id_Rm, id_uses_Rm, ex_Rd, ex_MemRead, ex_RegWrite, ex_BrTaken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_active, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_Rn, id_Rm, id_uses_Rm, ex_Rd, ex_MemRead, ex_RegWrite, ex_BrTaken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall_active, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller. Define HAZARD_PERF_CNT_EN to build the
// saturating stall/flush event counters; otherwise both counter outputs are tied to zero.
module hazard_ctrl (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_hazard;
  logic   w_run_flush;
  logic   w_run_stall;

  // Register x31 is the zero register, so a load targeting it never creates a dependency.
  assign w_hazard = hz.ex_MemRead && hz.ex_RegWrite && (hz.ex_Rd != 5'd31) &&
                    ((hz.ex_Rd == hz.id_Rn) || (hz.id_uses_Rm && (hz.ex_Rd == hz.id_Rm)));

  assign w_run_flush = (r_state == RUN) && hz.ex_BrTaken;
  assign w_run_stall = (r_state == RUN) && !hz.ex_BrTaken && w_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN: begin
        if (w_run_flush)      w_next = FLUSH;
        else if (w_run_stall) w_next = LDSTALL;
        else                  w_next = RUN;
      end
      LDSTALL: w_next = hz.ex_BrTaken ? FLUSH : RUN;
      FLUSH:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // Outputs are held low for the whole reset window, independent of the inputs.
  always_comb begin
    hz.pc_write     = 1'b0;
    hz.ifid_write   = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.stall_active = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (w_run_flush) begin
            hz.pc_write    = 1'b1;
            hz.ifid_write  = 1'b1;
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
          end else if (w_run_stall) begin
            hz.idex_bubble  = 1'b1;
            hz.stall_active = 1'b1;
          end else begin
            hz.pc_write   = 1'b1;
            hz.ifid_write = 1'b1;
          end
        end
        LDSTALL, FLUSH: begin
          hz.pc_write   = 1'b1;
          hz.ifid_write = 1'b1;
        end
        default: begin
          hz.pc_write   = 1'b0;
          hz.ifid_write = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_run_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_run_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 16'd0;
  assign hz.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  // Control outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}.
  logic [4:0] w_ctl;
  assign w_ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.stall_active};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    return CNT ? 16'(n) : 16'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_Rn       = 5'd0;
    bus.id_Rm       = 5'd0;
    bus.id_uses_Rm  = 1'b0;
    bus.ex_Rd       = 5'd0;
    bus.ex_MemRead  = 1'b0;
    bus.ex_RegWrite = 1'b0;
    bus.ex_BrTaken  = 1'b0;
  endtask

  task automatic load_rn5();
    bus.ex_MemRead  = 1'b1;
    bus.ex_RegWrite = 1'b1;
    bus.ex_Rd       = 5'd5;
    bus.id_Rn       = 5'd5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    bus.ex_BrTaken = 1'b1;
    #2;
    chk("rst_ctl", {11'd0, w_ctl}, 16'h0000);
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    chk("rst_flush_cnt", bus.flush_cnt, 16'd0);

    step();
    idle();
    reset = 1'b0;
    #1;
    chk("run_idle", {11'd0, w_ctl}, {11'd0, 5'b11000});

    // Load-use on Rn
    load_rn5();
    #1;
    chk("ldu_rn_stall", {11'd0, w_ctl}, {11'd0, 5'b00011});
    step();
    chk("ldu_rn_release", {11'd0, w_ctl}, {11'd0, 5'b11000});
    chk("ldu_rn_cnt", bus.stall_cnt, cnt_exp(1));
    idle();
    step();

    // Rm gating and x31
    bus.ex_MemRead = 1'b1; bus.ex_RegWrite = 1'b1; bus.ex_Rd = 5'd7;
    bus.id_Rm = 5'd7; bus.id_Rn = 5'd2; bus.id_uses_Rm = 1'b1;
    #1;
    chk("rm_used", {11'd0, w_ctl}, {11'd0, 5'b00011});
    bus.id_uses_Rm = 1'b0;
    #1;
    chk("rm_unused", {11'd0, w_ctl}, {11'd0, 5'b11000});
    bus.ex_Rd = 5'd31; bus.id_Rn = 5'd31;
    #1;
    chk("rd31", {11'd0, w_ctl}, {11'd0, 5'b11000});
    idle();

    // Branch and hazard together
    do_reset();
    load_rn5();
    bus.ex_BrTaken = 1'b1;
    #1;
    chk("simul_flush", {11'd0, w_ctl}, {11'd0, 5'b11110});
    step();
    chk("simul_next_ignored", {11'd0, w_ctl}, {11'd0, 5'b11000});
    chk("simul_flush_cnt", bus.flush_cnt, cnt_exp(1));
    chk("simul_stall_cnt", bus.stall_cnt, 16'd0);
    idle();
    step();

    // Back-to-back branches
    do_reset();
    bus.ex_BrTaken = 1'b1;
    #1;
    chk("br_c1", {15'd0, bus.ifid_flush}, 16'd1);
    step();
    chk("br_c2", {15'd0, bus.ifid_flush}, 16'd0);
    step();
    chk("br_c3", {15'd0, bus.ifid_flush}, 16'd1);
    step();
    chk("br_flush_cnt", bus.flush_cnt, cnt_exp(2));
    idle();
    step();

    // Reset mid-stall
    load_rn5();
    step();
    chk("ldstall_state", {11'd0, w_ctl}, {11'd0, 5'b11000});
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_ctl", {11'd0, w_ctl}, 16'h0000);
    chk("rst_mid_stall_cnt", bus.stall_cnt, 16'd0);
    step();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_release_pc", {15'd0, bus.pc_write}, 16'd1);
    chk("rst_release_fcnt", bus.flush_cnt, 16'd0);

    // Reset mid-flush, then first post-reset cycle must honour a branch from RUN
    bus.ex_BrTaken = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_flush_ctl", {11'd0, w_ctl}, 16'h0000);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_run_flush", {11'd0, w_ctl}, {11'd0, 5'b11110});
    idle();
    step();

    // Saturation
`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    dut.r_stall_cnt = 16'hFFFE;
`else
    do_reset();
`endif
    for (int i = 0; i < 3; i++) begin
      load_rn5();
      step();
      idle();
      step();
    end
    chk("sat_stall_cnt", bus.stall_cnt, CNT ? 16'hFFFF : 16'd0);
    chk("sat_flush_cnt", bus.flush_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
